sync_fifo: RTL and testbench

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO memory for blocks living in one clock domain. It wraps a dual-port storage array with pointer control, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags. It offers a registered standard read mode and a first-word-fall-through (FWFT) mode. It sits between producer and consumer datapaths, for example UART/DMA staging, where no clock crossing is needed.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/sync_fifo_ram.sv | 29 ++
 rtl/sync_fifo.sv | 155 +++++++++++++++
 tb/tb_sync_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: output-stage FSM encoding
// and a constant log2 helper used to validate the pointer width.
package fifo_pkg;

  // State of the FWFT output stage register.
  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int unsigned fifo_log2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage : fifo_pkg

// File: rtl/sync_fifo_ram.sv
// Dual-port storage array: synchronous write port, combinational read port.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Write port: store the word on the edge that accepts the write.
  // NOTE: the array deliberately has no reset; a reset loop over every entry
  // would prevent mapping onto RAM primitives, and the pointers already mark
  // every entry as invalid after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : sync_fifo_ram

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow and optional first-word-fall-through.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_WIDTH  = 4,
  parameter int AFULL_THR  = 12,
  parameter int AEMPTY_THR = 4,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  afull,
  output logic                  empty,
  output logic                  aempty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  if (PTR_WIDTH != fifo_log2(FIFO_DEPTH) || (1 << PTR_WIDTH) != FIFO_DEPTH
      || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("sync_fifo: FIFO_DEPTH must be a power of two >= 2 and PTR_WIDTH its log2");
  end

  localparam logic [PTR_WIDTH:0] PTR_ONE    = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0] DEPTH_LVL  = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] AFULL_LVL  = (PTR_WIDTH+1)'(AFULL_THR);
  localparam logic [PTR_WIDTH:0] AEMPTY_LVL = (PTR_WIDTH+1)'(AEMPTY_THR);

  logic [PTR_WIDTH:0]    wr_ptr, rd_ptr, count_q;
  logic [DATA_WIDTH-1:0] mem_rdata, rdata_q;
  logic                  rvalid_q, overflow_q, underflow_q;
  logic                  ptr_full, mem_empty, full_int, empty_int;
  logic                  wr_acc, rd_acc, mem_rd, fwft_load;
  out_state_e            state_q, state_d;

  // Memory full: same index, opposite wrap bit. Memory empty: equal pointers.
  assign ptr_full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                     (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
  assign mem_empty = (wr_ptr == rd_ptr);

  // In FWFT mode the output stage holds one extra word, so the count limit
  // closes the FIFO one entry before the memory pointers would.
  assign full_int  = ptr_full | (count_q == DEPTH_LVL);
  assign empty_int = FWFT ? (state_q == OUT_IDLE) : mem_empty;

  assign wr_acc = wr_en & ~full_int;
  assign rd_acc = rd_en & ~empty_int;
  assign mem_rd = FWFT ? fwft_load : rd_acc;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[PTR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[PTR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // Output-stage FSM next state: fetch the head whenever the stage is empty
  // or is being popped, as long as the memory has a word to give.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    fwft_load = 1'b0;
    case (state_q)
      OUT_IDLE: begin
        if (!mem_empty) begin
          fwft_load = 1'b1;
          state_d   = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (rd_acc) begin
          if (!mem_empty) fwft_load = 1'b1;
          else            state_d   = OUT_IDLE;
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  // Output-stage state register; held idle in standard mode.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst)       state_q <= OUT_IDLE;
    else if (FWFT) state_q <= state_d;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (mem_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered read data; rvalid pulses for one cycle per standard-mode read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (mem_rd) rdata_q <= mem_rdata;
      rvalid_q <= FWFT ? 1'b0 : rd_acc;
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (overflow_q  & ~clr_err) | (wr_en & full_int);
      underflow_q <= (underflow_q & ~clr_err) | (rd_en & empty_int);
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = FWFT ? ~empty_int : rvalid_q;
  assign full      = full_int;
  assign empty     = empty_int;
  assign count     = count_q;
  assign afull     = (count_q >= AFULL_LVL);
  assign aempty    = (count_q <= AEMPTY_LVL);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench: a standard-mode FIFO checked every cycle against a
// queue model, plus a FWFT instance for latency and pop-rate checks.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rvalid, full, afull, empty, aempty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [7:0] f_wdata = '0;
  logic [7:0] f_rdata;
  logic       f_rvalid, f_full, f_afull, f_empty, f_aempty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_rdata = '0;
  logic       m_rvalid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(.FWFT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .clr_err(clr_err), .rdata(rdata), .rvalid(rvalid), .full(full),
    .afull(afull), .empty(empty), .aempty(aempty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.FWFT(1'b1)) u_dut_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wdata(f_wdata), .rd_en(f_rd_en),
    .clr_err(f_clr_err), .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full),
    .afull(f_afull), .empty(f_empty), .aempty(f_aempty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every standard-mode output against the model.
  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"},     32'(count),     32'(n));
    check({tag, ".full"},      32'(full),      32'(n == 16));
    check({tag, ".afull"},     32'(afull),     32'(n >= 12));
    check({tag, ".empty"},     32'(empty),     32'(n == 0));
    check({tag, ".aempty"},    32'(aempty),    32'(n <= 4));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    check({tag, ".rvalid"},    32'(rvalid),    32'(m_rvalid));
    check({tag, ".rdata"},     32'(rdata),     32'(m_rdata));
  endtask

  // One clock of standard-mode stimulus with model update and full check.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c, input string tag);
    logic was_full, was_empty;
    wr_en = w; wdata = d; rd_en = r; clr_err = c;
    @(posedge clk);
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    m_rvalid = 1'b0;
    if (r && !was_empty) begin
      m_rdata  = q.pop_front();
      m_rvalid = 1'b1;
    end
    if (w && !was_full) q.push_back(d);
    m_ovf = (m_ovf & ~c) | (w & was_full);
    m_unf = (m_unf & ~c) | (r & was_empty);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  // Synchronous reset of both instances, optionally with a competing write.
  task automatic do_reset(input logic w);
    rst = 1'b1; wr_en = w; wdata = 8'hEE; f_wr_en = w; f_wdata = 8'hEE;
    @(posedge clk);
    q.delete();
    m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    rst = 1'b0; wr_en = 1'b0; f_wr_en = 1'b0;
    check_all("reset");
    check("reset.f_count",  32'(f_count),  32'd0);
    check("reset.f_empty",  32'(f_empty),  32'd1);
    check("reset.f_rvalid", 32'(f_rvalid), 32'd0);
    check("reset.f_rdata",  32'(f_rdata),  32'd0);
    check("reset.f_aempty", 32'(f_aempty), 32'd1);
  endtask

  // One clock of FWFT-instance stimulus; the standard instance idles.
  task automatic fstep(input logic w, input logic [7:0] d, input logic r);
    f_wr_en = w; f_wdata = d; f_rd_en = r;
    @(posedge clk);
    m_rvalid = 1'b0;
    #1;
    f_wr_en = 1'b0; f_rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] dat;

    do_reset(1'b0);

    // 1. Fill and overflow
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
    step(1'b1, 8'hFF, 1'b0, 1'b0, "overflow");
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");

    // 2. Drain and underflow
    for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("drain%0d", i));
    step(1'b0, 8'h00, 1'b1, 1'b0, "underflow");
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_unf");

    // 3. Wrap-around
    dat = 8'h20;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 10; i++) begin
        step(1'b1, dat, 1'b0, 1'b0, $sformatf("wrap_w%0d_%0d", rnd, i));
        dat++;
      end
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("wrap_r%0d_%0d", rnd, i));
    end

    // 4. Simultaneous read and write
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "sim_fill");
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, $sformatf("sim_rw%0d", i));
    for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "sim_top");
    step(1'b1, 8'hEE, 1'b1, 1'b0, "full_rw");
    step(1'b0, 8'h00, 1'b0, 1'b1, "full_clr");
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "sim_drain");

    // 6. Reset mid-stream
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "pre_rst");
    do_reset(1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b0, "post_rst_w");
    step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_r");

    // 5. FWFT latency and back-to-back pops
    fstep(1'b1, 8'hA5, 1'b0);
    check("fwft.k.empty", 32'(f_empty), 32'd1);
    check("fwft.k.count", 32'(f_count), 32'd1);
    fstep(1'b0, 8'h00, 1'b0);
    check("fwft.k1.rdata",  32'(f_rdata),  32'hA5);
    check("fwft.k1.empty",  32'(f_empty),  32'd0);
    check("fwft.k1.rvalid", 32'(f_rvalid), 32'd1);
    fstep(1'b0, 8'h00, 1'b1);
    check("fwft.pop.empty", 32'(f_empty), 32'd1);
    check("fwft.pop.count", 32'(f_count), 32'd0);
    for (int i = 0; i < 3; i++) fstep(1'b1, 8'(8'hB0 + i), 1'b0);
    fstep(1'b0, 8'h00, 1'b0);
    check("fwft.b2b.head",  32'(f_rdata), 32'hB0);
    check("fwft.b2b.count", 32'(f_count), 32'd3);
    for (int i = 1; i < 3; i++) begin
      fstep(1'b0, 8'h00, 1'b1);
      check($sformatf("fwft.b2b.rdata%0d", i), 32'(f_rdata), 32'(8'hB0 + i));
      check($sformatf("fwft.b2b.valid%0d", i), 32'(f_rvalid), 32'd1);
      check($sformatf("fwft.b2b.count%0d", i), 32'(f_count), 32'(3 - i));
    end
    fstep(1'b0, 8'h00, 1'b1);
    check("fwft.b2b.empty", 32'(f_empty), 32'd1);
    fstep(1'b0, 8'h00, 1'b1);
    check("fwft.underflow", 32'(f_underflow), 32'd1);

    // Resync the standard instance's model after idle cycles.
    step(1'b0, 8'h00, 1'b0, 1'b0, "resync");

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      logic w, r, c;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 5);
      step(w, 8'($urandom), r, c, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sync_fifo
